// File: rtl/cam_capture_px.sv
// OV7670 pixel-capture front end: assembles RGB565 byte pairs, converts format, crops, writes to frame buffer.
// Optional 2x decimation is enabled by defining CAM_DECIMATE_EN.
module cam_capture_px #(
  parameter int AW    = 17,
  parameter int DW    = 16,
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          start,
  input  logic          cont,
  input  logic [1:0]    fmt,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          frame_done,
  output logic          err_odd
);

  localparam int CW = 16;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

`ifdef CAM_DECIMATE_EN
  localparam logic [CW-1:0] H_LIM = CW'(2 * H_RES);
  localparam logic [CW-1:0] V_LIM = CW'(2 * V_RES);
`else
  localparam logic [CW-1:0] H_LIM = CW'(H_RES);
  localparam logic [CW-1:0] V_LIM = CW'(V_RES);
`endif
  localparam logic [AW-1:0] ADDR_LAST = AW'(H_RES * V_RES - 1);

  logic [1:0]    state_q, state_d;
  logic          vsync_q, href_q;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] line_q, line_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic [1:0]    fmt_q, fmt_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          vs_rise, vs_fall, href_fall;
  logic          in_window, do_write, err_set;
  logic [15:0]   pix, conv;

  assign vs_rise   = vsync & ~vsync_q;
  assign vs_fall   = ~vsync & vsync_q;
  assign href_fall = ~href & href_q;
  assign pix       = {hi_q, px_data};

`ifdef CAM_DECIMATE_EN
  assign in_window = (col_q < H_LIM) && (line_q < V_LIM) && !col_q[0] && !line_q[0];
`else
  assign in_window = (col_q < H_LIM) && (line_q < V_LIM);
`endif

  assign do_write = (state_q == S_CAPTURE) && href && !vs_rise && phase_q && in_window && !full_q;

  always_comb begin
    conv = '0;
    case (fmt_q)
      2'b01:   conv = {4'h0, pix[15:12], pix[10:7], pix[4:1]};
      2'b10:   conv = pix;
      default: conv = {8'h00, pix[15:13], pix[10:8], pix[4:3]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    col_d   = col_q;
    line_d  = line_q;
    addr_d  = addr_q;
    full_d  = full_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    fmt_d   = fmt_q;
    err_set = 1'b0;

    // Address moves on the edge after a write so it names the current write while px_wr is high.
    if (wr_q && !full_q) begin
      addr_d = addr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start || cont) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (vs_fall) begin
          state_d = S_CAPTURE;
          fmt_d   = fmt;
          addr_d  = '0;
          col_d   = '0;
          line_d  = '0;
          phase_d = 1'b0;
          full_d  = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (vs_rise) begin
          state_d = S_DONE;
          phase_d = 1'b0;
        end else if (href) begin
          if (!phase_q) begin
            hi_d    = px_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            col_d   = (col_q == '1) ? col_q : col_q + 1'b1;
            if (do_write) begin
              wr_d        = 1'b1;
              data_d      = '0;
              data_d[15:0] = conv;
              if (addr_q == ADDR_LAST) full_d = 1'b1;
            end
          end
        end else if (href_fall) begin
          col_d   = '0;
          phase_d = 1'b0;
          err_set = phase_q;
          if (col_q != '0 && line_q != '1) line_d = line_q + 1'b1;
        end
      end
      default: begin
        state_d = (cont || start) ? S_ARMED : S_IDLE;
      end
    endcase

    err_d = err_q;
    if (start)   err_d = 1'b0;
    if (err_set) err_d = 1'b1;

    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE) || ((state_d == S_DONE) && cont);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      col_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      full_q  <= 1'b0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      fmt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      href_q  <= href;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      col_q   <= col_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      full_q  <= full_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      fmt_q   <= fmt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign mem_px_addr = addr_q;
  assign mem_px_data = data_q;
  assign px_wr       = wr_q;
  assign busy        = busy_q;
  assign frame_done  = (state_q == S_DONE);
  assign err_odd     = err_q;

endmodule

// File: tb/tb_cam_capture_px.sv
// Directed bench for cam_capture_px: scoreboard of expected writes, immediate-assertion checks.
module tb_cam_capture_px;
  localparam int AW = 17;
  localparam int DW = 16;
  localparam int H  = 4;
  localparam int V  = 2;
`ifdef CAM_DECIMATE_EN
  localparam int HL = 2 * H;
  localparam int VL = 2 * V;
`else
  localparam int HL = H;
  localparam int VL = V;
`endif

  logic          pclk = 1'b0;
  logic          rst, start, cont, vsync, href;
  logic [1:0]    fmt;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr, busy, frame_done, err_odd;

  cam_capture_px #(.AW(AW), .DW(DW), .H_RES(H), .V_RES(V)) dut (
    .pclk(pclk), .rst(rst), .start(start), .cont(cont), .fmt(fmt),
    .vsync(vsync), .href(href), .px_data(px_data),
    .mem_px_addr(mem_px_addr), .mem_px_data(mem_px_data), .px_wr(px_wr),
    .busy(busy), .frame_done(frame_done), .err_odd(err_odd)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t  exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   fd_count = 0;
  int   m_col, m_line, m_addr;
  bit   m_full;
  logic [1:0] m_fmt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [1:0] f, input logic [15:0] p);
    case (f)
      2'b01:   return {4'h0, p[15:12], p[10:7], p[4:1]};
      2'b10:   return p;
      default: return {8'h00, p[15:13], p[10:8], p[4:3]};
    endcase
  endfunction

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Scoreboard pop side.
  always @(negedge pclk) begin
    if (!rst && frame_done) fd_count++;
    if (!rst && px_wr) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'(px_wr), 32'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        $display("write addr=%0d data=%04h expect addr=%0d data=%04h", mem_px_addr, mem_px_data, w.a, w.d);
        chk("wr_addr", 32'(mem_px_addr), 32'(w.a));
        chk("wr_data", 32'(mem_px_data), 32'(w.d));
      end
    end
  end

  function automatic bit model_px(input logic [15:0] ed);
    bit inw, w;
    wr_t e;
    inw = (m_col < HL) && (m_line < VL);
`ifdef CAM_DECIMATE_EN
    inw = inw && (m_col % 2 == 0) && (m_line % 2 == 0);
`endif
    w = inw && !m_full;
    if (w) begin
      e.a = AW'(m_addr);
      e.d = ed;
      exp_q.push_back(e);
      if (m_addr == H * V - 1) m_full = 1'b1;
      else m_addr++;
    end
    m_col++;
    return w;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic begin_frame(input logic [1:0] f);
    fmt = f;
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    m_col = 0; m_line = 0; m_addr = 0; m_full = 1'b0; m_fmt = f;
  endtask

  task automatic line(input int nbytes, input bit rnd, input logic [15:0] pix, input logic [15:0] ed);
    logic [15:0] cur;
    bit w;
    cur = pix;
    for (int i = 0; i < nbytes; i++) begin
      if (i % 2 == 0) begin
        if (rnd) cur = 16'($urandom);
        px_data = cur[15:8];
      end else begin
        px_data = cur[7:0];
      end
      href = 1'b1;
      tick();
      if (i % 2 == 1) begin
        w = model_px(rnd ? conv(m_fmt, cur) : ed);
        chk("wr_strobe", 32'(px_wr), 32'(w));
      end
    end
    href = 1'b0;
    px_data = 8'h00;
    tick();
    if (nbytes % 2 == 1) chk("err_odd_set", 32'(err_odd), 32'd1);
    if (m_col > 0) m_line++;
    m_col = 0;
    tick();
  endtask

  task automatic end_frame(input bit exp_busy);
    vsync = 1'b1;
    tick();
    chk("frame_done", 32'(frame_done), 32'd1);
    chk("busy_in_done", 32'(busy), 32'(exp_busy));
    tick();
    chk("frame_done_clr", 32'(frame_done), 32'd0);
    chk("busy_after", 32'(busy), 32'(exp_busy));
  endtask

  initial begin
    int fd0;
    rst = 1'b1; start = 1'b0; cont = 1'b0; fmt = 2'b00;
    vsync = 1'b0; href = 1'b0; px_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_addr", 32'(mem_px_addr), 32'd0);
    chk("rst_data", 32'(mem_px_data), 32'd0);
    chk("rst_wr", 32'(px_wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err_odd), 32'd0);

    // RGB332 of pure red.
    pulse_start();
    chk("busy_armed", 32'(busy), 32'd1);
    begin_frame(2'b00);
    for (int l = 0; l < 2; l++) line(8, 1'b0, 16'hF800, 16'h00E0);
    end_frame(1'b0);

    // RGB444 / RGB565 of pure green, and fmt=11 aliasing RGB332.
    pulse_start();
    begin_frame(2'b01);
    line(8, 1'b0, 16'h07E0, 16'h00F0);
    end_frame(1'b0);
    pulse_start();
    begin_frame(2'b10);
    line(8, 1'b0, 16'h07E0, 16'h07E0);
    end_frame(1'b0);
    pulse_start();
    begin_frame(2'b11);
    line(8, 1'b0, 16'hF800, 16'h00E0);
    end_frame(1'b0);

    // Over-wide lines and extra lines get cropped.
    pulse_start();
    begin_frame(2'b10);
    for (int l = 0; l < 3; l++) line(12, 1'b1, 16'h0000, 16'h0000);
    end_frame(1'b0);

    // Odd byte count sets sticky error; next line realigns.
    pulse_start();
    begin_frame(2'b00);
    line(7, 1'b1, 16'h0000, 16'h0000);
    line(8, 1'b1, 16'h0000, 16'h0000);
    end_frame(1'b0);
    chk("err_sticky", 32'(err_odd), 32'd1);
    pulse_start();
    chk("err_cleared", 32'(err_odd), 32'd0);

    // 8x4 source frame (decimation target when enabled).
    begin_frame(2'b01);
    for (int l = 0; l < 4; l++) line(16, 1'b1, 16'h0000, 16'h0000);
    end_frame(1'b0);

    // Continuous mode across two frames.
    fd0 = fd_count;
    cont = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      begin_frame(2'b10);
      for (int l = 0; l < 2; l++) line(8, 1'b1, 16'h0000, 16'h0000);
      end_frame(1'b1);
    end
    cont = 1'b0;
    chk("cont_frames", 32'(fd_count - fd0), 32'd2);

    // Reset during a write cycle.
    begin_frame(2'b10);
    href = 1'b1; px_data = 8'hAB;
    tick();
    px_data = 8'hCD;
    tick();
    chk("pre_rst_wr", 32'(px_wr), 32'd1);
    chk("pre_rst_data", 32'(mem_px_data), 32'hABCD);
    rst = 1'b1;
    #1;
    chk("rst_mid_wr", 32'(px_wr), 32'd0);
    chk("rst_mid_addr", 32'(mem_px_addr), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    href = 1'b0;
    tick();
    rst = 1'b0;
    vsync = 1'b1;
    tick();
    tick();
    vsync = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      href = 1'b1;
      px_data = 8'(i * 37);
      tick();
      if (i % 2 == 1) chk("no_wr_unarmed", 32'(px_wr), 32'd0);
    end
    href = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
